dmem_arbiter: RTL and testbench

Arbiter and sequencer for the shared data-memory/bridge port. It sits between the CPU MEM stage (the port whose byte enables come from the byte-enable generator) and a secondary bus master (DMA/debug). Each transaction is granted round-robin and its request fields are latched onto the memory bus. The block waits for the memory ready, returns read data with a one-cycle ack, and aborts with a bus error after a timeout so the interrupt/exception logic can act.

---
 rtl/dmem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and bus sequencer for the shared
// data-memory port between the CPU MEM stage and a DMA/debug master.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | no bus cycle; arbitrate between unmasked requesters
// BUSY_CPU | CPU transaction on the bus, waiting for mem_rdy/timeout
// BUSY_DMA | DMA transaction on the bus, waiting for mem_rdy/timeout
module dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic [3:0]    cpu_be,
    output logic          cpu_ack,
    output logic          cpu_err,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_we,
    input  logic [3:0]    dma_be,
    output logic          dma_ack,
    output logic          dma_err,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_sel,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_DMA} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_dma_q, last_dma_d;   // 1: most recent grant went to DMA
    logic          mem_sel_q, mem_sel_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic          cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d;
    logic          dma_ack_q, dma_ack_d, dma_err_q, dma_err_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;

    logic cpu_elig, dma_elig, grant_cpu, grant_dma, tmo;

    // A requester being acked this cycle still holds req; mask it so it is not re-granted.
    assign cpu_elig  = cpu_req & ~cpu_ack_q;
    assign dma_elig  = dma_req & ~dma_ack_q;
    assign grant_cpu = cpu_elig & (~dma_elig | last_dma_q);
    assign grant_dma = dma_elig & ~grant_cpu;
    assign tmo       = ~mem_rdy & (cnt_q == CW'(TIMEOUT - 1));

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_dma_q  <= 1'b1;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_ack_q   <= 1'b0;
            dma_err_q   <= 1'b0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dma_q  <= last_dma_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_ack_q   <= dma_ack_d;
            dma_err_q   <= dma_err_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Next-state: grant from IDLE, return on ready or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_cpu)      state_d = BUSY_CPU;
                else if (grant_dma) state_d = BUSY_DMA;
            end
            BUSY_CPU, BUSY_DMA: begin
                if (mem_rdy || tmo) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath: latch fields at grant, complete or abort the bus cycle.
    always_comb begin
        cnt_d       = cnt_q;
        last_dma_d  = last_dma_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        cpu_rdata_d = '0;
        dma_ack_d   = 1'b0;
        dma_err_d   = 1'b0;
        dma_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (grant_cpu || grant_dma) begin
                    mem_sel_d   = 1'b1;
                    cnt_d       = '0;
                    last_dma_d  = grant_dma;
                    mem_addr_d  = grant_cpu ? cpu_addr  : dma_addr;
                    mem_wdata_d = grant_cpu ? cpu_wdata : dma_wdata;
                    mem_we_d    = grant_cpu ? cpu_we    : dma_we;
                    mem_be_d    = grant_cpu ? cpu_be    : dma_be;
                end
            end
            BUSY_CPU, BUSY_DMA: begin
                if (mem_rdy || tmo) begin
                    mem_sel_d = 1'b0;
                    if (state_q == BUSY_CPU) begin
                        cpu_ack_d   = 1'b1;
                        cpu_err_d   = tmo;
                        cpu_rdata_d = (mem_rdy && !mem_we_q) ? mem_rdata : '0;
                    end else begin
                        dma_ack_d   = 1'b1;
                        dma_err_d   = tmo;
                        dma_rdata_d = (mem_rdy && !mem_we_q) ? mem_rdata : '0;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_ack   = dma_ack_q;
    assign dma_err   = dma_err_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;
    assign mem_sel   = mem_sel_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized phase, checked against
// a transaction-level model of the arbiter.
module tb_dmem_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0, mem_rdy = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
    logic [3:0]  cpu_be = 0, dma_be = 0;
    logic        cpu_ack, cpu_err, cpu_stall, dma_ack, dma_err, mem_sel, mem_we;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int checks = 0, failures = 0;

    // model: owner 0 = none, 1 = CPU, 2 = DMA; elapsed = mem_sel cycles so far
    int          m_owner, m_elapsed;
    bit          m_last_cpu;
    logic        e_mem_sel, e_mem_we, e_cpu_ack, e_cpu_err, e_dma_ack, e_dma_err;
    logic [31:0] e_mem_addr, e_mem_wdata, e_cpu_rdata, e_dma_rdata;
    logic [3:0]  e_mem_be;

    dmem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
        .dma_be(dma_be), .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_elapsed = 0; m_last_cpu = 1'b0;
        e_mem_sel = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0; e_mem_be = 0;
        e_cpu_ack = 0; e_cpu_err = 0; e_cpu_rdata = 0;
        e_dma_ack = 0; e_dma_err = 0; e_dma_rdata = 0;
    endtask

    // Predict the effect of the coming clock edge from the current inputs.
    task automatic model_step();
        bit ce, de, err;
        logic [31:0] rd;
        ce = cpu_req && !e_cpu_ack;
        de = dma_req && !e_dma_ack;
        e_cpu_ack = 0; e_cpu_err = 0; e_cpu_rdata = 0;
        e_dma_ack = 0; e_dma_err = 0; e_dma_rdata = 0;
        if (m_owner != 0) begin
            if (mem_rdy || m_elapsed == TIMEOUT) begin
                err = !mem_rdy;
                rd  = (mem_rdy && !e_mem_we) ? mem_rdata : 32'h0;
                if (m_owner == 1) begin e_cpu_ack = 1; e_cpu_err = err; e_cpu_rdata = rd; end
                else              begin e_dma_ack = 1; e_dma_err = err; e_dma_rdata = rd; end
                e_mem_sel = 0;
                m_owner   = 0;
            end else begin
                m_elapsed++;
            end
        end else if (ce || de) begin
            if (ce && (!de || !m_last_cpu)) begin
                m_owner = 1;
                e_mem_addr = cpu_addr; e_mem_wdata = cpu_wdata; e_mem_we = cpu_we; e_mem_be = cpu_be;
            end else begin
                m_owner = 2;
                e_mem_addr = dma_addr; e_mem_wdata = dma_wdata; e_mem_we = dma_we; e_mem_be = dma_be;
            end
            m_last_cpu = (m_owner == 1);
            e_mem_sel  = 1;
            m_elapsed  = 1;
        end
    endtask

    task automatic check_all();
        chk("mem_sel", mem_sel, e_mem_sel);
        if (e_mem_sel) begin
            chk("mem_addr", mem_addr, e_mem_addr);
            chk("mem_wdata", mem_wdata, e_mem_wdata);
            chk("mem_we", mem_we, e_mem_we);
            chk("mem_be", mem_be, e_mem_be);
        end
        chk("cpu_ack", cpu_ack, e_cpu_ack);
        chk("dma_ack", dma_ack, e_dma_ack);
        if (e_cpu_ack) begin
            chk("cpu_err", cpu_err, e_cpu_err);
            chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
        end
        if (e_dma_ack) begin
            chk("dma_err", dma_err, e_dma_err);
            chk("dma_rdata", dma_rdata, e_dma_rdata);
        end
        chk("cpu_stall", cpu_stall, cpu_req & ~e_cpu_ack);
        chk("ack_exclusive", cpu_ack & dma_ack, 1'b0);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drain();
        cpu_req = 0; dma_req = 0; mem_rdy = 1;
        repeat (3) cycle();
        mem_rdy = 0;
    endtask

    initial begin
        int q[$];
        int n_sel, lat, p;
        bit got;

        // reset values, applied asynchronously before any clock edge
        model_reset();
        #3;
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_acks", {cpu_ack, cpu_err, dma_ack, dma_err}, 0);
        chk("rst_rdata", {cpu_rdata, dma_rdata}, 0);
        @(posedge clk); #1;
        rst = 0;
        check_all();

        // both requesters held high, memory always ready: strict alternation from CPU
        cpu_req = 1; dma_req = 1; mem_rdy = 1;
        cpu_addr = 32'h1000; dma_addr = 32'h2000;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (cpu_ack) q.push_back(1);
            if (dma_ack) q.push_back(2);
        end
        chk("rr_count", q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_order%0d", i), (i < q.size()) ? q[i] : -1, (i % 2 == 0) ? 1 : 2);
        drain();

        // CPU read, ready two cycles after mem_sel rises
        cpu_req = 1; cpu_addr = 32'h100; cpu_be = 4'hF; cpu_we = 0; mem_rdy = 0;
        cycle();
        chk("rd_mem_sel", mem_sel, 1);
        chk("rd_mem_addr", mem_addr, 32'h100);
        chk("rd_stall", cpu_stall, 1);
        cycle();
        chk("rd_stall2", cpu_stall, 1);
        mem_rdy = 1; mem_rdata = 32'hDEADBEEF;
        cycle();
        chk("rd_ack", cpu_ack, 1);
        chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd_err", cpu_err, 0);
        chk("rd_stall_ack", cpu_stall, 0);
        cpu_req = 0; mem_rdy = 0;
        cycle();

        // DMA byte write, memory ready in the first bus cycle
        dma_req = 1; dma_addr = 32'h203; dma_be = 4'b1000; dma_wdata = 32'h55000000; dma_we = 1;
        mem_rdy = 1; mem_rdata = 32'hA5A51234;
        cycle();
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_be", mem_be, 4'b1000);
        chk("wr_mem_wdata", mem_wdata, 32'h55000000);
        chk("wr_mem_addr", mem_addr, 32'h203);
        cycle();
        chk("wr_ack", dma_ack, 1);
        chk("wr_rdata", dma_rdata, 0);
        dma_req = 0; dma_we = 0; mem_rdy = 0;
        cycle();

        // CPU read that never sees ready: timeout abort
        cpu_req = 1; cpu_addr = 32'h300; cpu_we = 0; mem_rdy = 0; mem_rdata = 32'h12345678;
        cycle();
        n_sel = 0; lat = 1; got = 0;
        for (int i = 0; i < 40; i++) begin
            if (cpu_ack) begin got = 1; break; end
            if (mem_sel) n_sel++;
            cycle();
            lat++;
        end
        chk("to_ack_seen", got, 1);
        chk("to_sel_cycles", n_sel, TIMEOUT);
        chk("to_latency", lat, TIMEOUT + 1);
        chk("to_err", cpu_err, 1);
        chk("to_rdata", cpu_rdata, 0);
        cpu_req = 0;
        cycle();
        chk("to_idle", mem_sel, 0);

        // ready arrives exactly in the last allowed cycle: normal completion
        cpu_req = 1; cpu_addr = 32'h400; cpu_we = 0; mem_rdy = 0;
        cycle();
        repeat (TIMEOUT - 1) cycle();
        chk("late_sel", mem_sel, 1);
        mem_rdy = 1; mem_rdata = 32'hCAFEF00D;
        cycle();
        chk("late_ack", cpu_ack, 1);
        chk("late_err", cpu_err, 0);
        chk("late_rdata", cpu_rdata, 32'hCAFEF00D);
        cpu_req = 0; mem_rdy = 0;
        cycle();

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            p = ((i / 250) % 3 == 0) ? 70 : (((i / 250) % 3 == 1) ? 25 : 4);
            if (cpu_req && e_cpu_ack) cpu_req = 1'($urandom_range(0, 1));
            else if (!cpu_req)        cpu_req = ($urandom_range(0, 3) == 0);
            if (dma_req && e_dma_ack) dma_req = 1'($urandom_range(0, 1));
            else if (!dma_req)        dma_req = ($urandom_range(0, 3) == 0);
            cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom); cpu_be = 4'($urandom);
            dma_addr = $urandom; dma_wdata = $urandom; dma_we = 1'($urandom); dma_be = 4'($urandom);
            mem_rdy = ($urandom_range(0, 99) < p);
            mem_rdata = $urandom;
            cycle();
        end
        drain();

        // reset three cycles into a DMA transaction
        dma_req = 1; dma_addr = 32'h500; dma_we = 0; dma_be = 4'hF; mem_rdy = 0;
        cycle();
        cycle();
        cycle();
        chk("mid_busy", mem_sel, 1);
        #2;
        rst = 1;
        #1;
        chk("arst_mem_sel", mem_sel, 0);
        chk("arst_dma_ack", dma_ack, 0);
        chk("arst_dma_err", dma_err, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_we_be", {mem_we, mem_be}, 0);
        model_reset();
        cpu_req = 1; dma_req = 1; cpu_addr = 32'h600; cpu_we = 0;
        @(posedge clk); #1;
        chk("rst_hold_ack", {cpu_ack, dma_ack}, 0);
        rst = 0;
        cycle();
        chk("post_rst_addr", mem_addr, 32'h600);
        mem_rdy = 1;
        cycle();
        chk("post_rst_cpu_first", cpu_ack, 1);
        chk("post_rst_no_dma", dma_ack, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
